instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 8, width of the program-memory word address.
REQ-003 SHALL have port clk, in, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, in, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, in, 1, field bundle valid.
REQ-006 SHALL have port in_ready, out, 1, encoder accepts the bundle this cycle.
REQ-007 SHALL have input field ports: in_cond[3:0], in_op[1:0], in_imm_sel[0], in_bits[3:0], in_set_flags[0], in_link[0], in_base[3:0], in_reg[3:0], in_imm12[11:0], in_imm24[23:0].
REQ-008 SHALL have port start_load, in, 1, loads out_addr from start_addr.
REQ-009 SHALL have port start_addr, in, ADDR_W, first write address.
REQ-010 SHALL have port out_valid, out, 1, encoded word valid.
REQ-011 SHALL have port out_ready, in, 1, the program-memory writer accepts the word.
REQ-012 SHALL have port out_word, out, 32, encoded instruction.
REQ-013 SHALL have port out_addr, out, ADDR_W, write address of out_word.
REQ-014 SHALL have port err, out, 1, one-cycle illegal-bundle pulse (present only with ENC_FIELD_CHECK_EN).

Function
REQ-015 SHALL transfer the input when in_valid && in_ready, and the output when out_valid && out_ready.
REQ-016 SHALL always encode [31:28]=cond and [27:26]=op.
REQ-017 SHALL encode op=00 (data) as [25]=imm_sel, [24:21]=bits, [20]=set_flags, [19:16]=base, [15:12]=reg, [11:0]=imm12.
REQ-018 SHALL encode op=01 (memory) as [25]=imm_sel, [24]=link (1=load), [23:20]=0, [19:16]=base, [15:12]=reg, [11:0]=imm12.
REQ-019 SHALL encode op=10 (branch) as [25]=0, [24]=link, [23:0]=imm24.
REQ-020 SHALL encode op=11 as all-zero in [25:0].
REQ-021 SHALL register the encoded word in a one-stage pipeline register, then push it into the FIFO; the word SHALL become visible on out_word no earlier than 2 cycles after acceptance when the FIFO was empty.
REQ-022 SHALL drive in_ready=1 when the pipeline stage is empty, or when it can drain into the FIFO in the same cycle.
REQ-023 SHALL drive in_ready=0 when the FIFO is full and the stage is occupied.
REQ-024 SHALL drive out_word/out_addr from the FIFO head while out_valid=1.
REQ-025 SHALL hold out_word/out_addr stable while out_valid && !out_ready.
REQ-026 SHALL increment out_addr by 1 on each output transfer, wrapping from 2^ADDR_W-1 to 0.
REQ-027 SHALL give start_load priority over the increment when both occur in the same cycle; start_load SHALL NOT flush the FIFO.
REQ-028 SHALL allow a FIFO push and pop in the same cycle when full, keeping occupancy unchanged.
REQ-029 SHALL keep ordering strictly FIFO, with no word lost or duplicated.

Reset
REQ-030 SHALL, while rst=1, force in_ready=0, out_valid=0, out_word=0, out_addr=0, err=0, empty the pipeline and FIFO, and clear all pointers.
REQ-031 SHALL discard any in-flight words when reset is asserted mid-operation.
REQ-032 SHALL drive in_ready=1 on the first clk edge after rst deasserts.

Configuration
REQ-033 SHALL, with ENC_FIELD_CHECK_EN defined, accept bundles with op=11, or op=10 with imm_sel=1, pulse err for one cycle, and push nothing into the FIFO.
REQ-034 SHALL, without ENC_FIELD_CHECK_EN, omit err and encode such bundles per REQ-019/REQ-020.

Structure
REQ-035 SHALL place the op enum (OP_DATA=00, OP_MEM=01, OP_BR=10, OP_RSVD=11) and the field bit-position constants in package enc_pkg, shared with the decoder.
REQ-036 SHALL implement the buffer as sub-module enc_fifo (parameterised width and depth, with full/empty flags).

Verification
REQ-037 SHALL cover: a data op with cond=E, imm_sel=1, bits=4, S=1, base=1, reg=2, imm12=0x0FF -> out_word=0xE29120FF at out_addr=0.
REQ-038 SHALL cover: a branch with cond=E, link=1, imm24=0x000010 -> 0xE9000010; then a memory op with cond=E, link=1, base=3, reg=4, imm12=0x008 -> 0xE5034008 at addr 1, 2 in order.
REQ-039 SHALL cover: out_ready=0 with 6 bundles offered -> exactly 5 accepted (4 FIFO + 1 stage), then in_ready=0; release -> 5 words at consecutive addresses.
REQ-040 SHALL cover: start_load with start_addr=0xFF, two words -> out_addr 0xFF then 0x00.
REQ-041 SHALL cover: rst asserted with 3 words buffered -> out_valid=0 immediately, out_addr=0, no stale words after release.
REQ-042 SHALL cover: op=11 with ENC_FIELD_CHECK_EN -> single err pulse, no output; without the macro -> out_word=0x{cond}C000000.

Source files
------------

// File: rtl/enc_pkg.sv
// -----------------------------------------------------------------------------
// enc_pkg -- shared instruction-format definitions for the encoder and decoder.
//   op_e          : major opcode encoding (bits [27:26])
//   *_LSB / *_BIT : field bit positions inside the 32-bit instruction word
//   encode_word() : packs a field bundle into a 32-bit word
//   is_illegal()  : flags bundles the field checker rejects
// -----------------------------------------------------------------------------
package enc_pkg;

    typedef enum logic [1:0] {
        OP_DATA = 2'b00,
        OP_MEM  = 2'b01,
        OP_BR   = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int IMM_BIT   = 25;
    localparam int BITS_MSB  = 24;
    localparam int BITS_LSB  = 21;
    localparam int LINK_BIT  = 24;
    localparam int S_BIT     = 20;
    localparam int BASE_MSB  = 19;
    localparam int BASE_LSB  = 16;
    localparam int REG_MSB   = 15;
    localparam int REG_LSB   = 12;
    localparam int IMM12_MSB = 11;
    localparam int IMM24_MSB = 23;

    function automatic logic [31:0] encode_word(
        input logic [3:0]  cond,
        input op_e         op,
        input logic        imm_sel,
        input logic [3:0]  bits,
        input logic        set_flags,
        input logic        link,
        input logic [3:0]  base,
        input logic [3:0]  rg,
        input logic [11:0] imm12,
        input logic [23:0] imm24
    );
        logic [31:0] w;
        w = '0;
        w[COND_MSB:COND_LSB] = cond;
        w[OP_MSB:OP_LSB]     = op;
        case (op)
            OP_DATA: begin
                w[IMM_BIT]            = imm_sel;
                w[BITS_MSB:BITS_LSB]  = bits;
                w[S_BIT]              = set_flags;
                w[BASE_MSB:BASE_LSB]  = base;
                w[REG_MSB:REG_LSB]    = rg;
                w[IMM12_MSB:0]        = imm12;
            end
            OP_MEM: begin
                // [23:20] stay zero for memory ops
                w[IMM_BIT]            = imm_sel;
                w[LINK_BIT]           = link;
                w[BASE_MSB:BASE_LSB]  = base;
                w[REG_MSB:REG_LSB]    = rg;
                w[IMM12_MSB:0]        = imm12;
            end
            OP_BR: begin
                // imm_sel has no meaning for branches; [25] is always zero
                w[LINK_BIT]           = link;
                w[IMM24_MSB:0]        = imm24;
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic is_illegal(input op_e op, input logic imm_sel);
        return (op == OP_RSVD) || ((op == OP_BR) && imm_sel);
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// -----------------------------------------------------------------------------
// enc_fifo -- synchronous FIFO with full/empty flags.
//   Parameters: WIDTH (data bits), DEPTH (entries, power of two)
//   clk, rst      : clock, async active-high reset (empties the FIFO)
//   push_i/wdata_i: write request and data; ignored when full unless popping
//   pop_i         : read request; ignored when empty
//   rdata_o       : head entry (valid while !empty_o)
//   full_o/empty_o: occupancy flags
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module enc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en, rd_en;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder -- packs instruction field bundles into 32-bit words and
// streams them, with write addresses, to a program-memory writer.
//   Parameters: FIFO_DEPTH (output buffer words), ADDR_W (address width)
//   clk, rst              : clock, async active-high reset
//   in_valid/in_ready     : field-bundle handshake
//   in_cond..in_imm24     : instruction fields
//   start_load/start_addr : reload the write address
//   out_valid/out_ready   : encoded-word handshake
//   out_word/out_addr     : encoded word and its write address
//   err                   : one-cycle illegal-bundle pulse
// Build option: define ENC_FIELD_CHECK_EN to reject reserved ops and branches
// with imm_sel=1 (they are consumed, flagged on err, and never emitted).
// Datapath: bundle -> one-stage register -> enc_fifo -> output.
// -----------------------------------------------------------------------------
module instr_encoder
    import enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic              in_imm_sel,
    input  logic [3:0]        in_bits,
    input  logic              in_set_flags,
    input  logic              in_link,
    input  logic [3:0]        in_base,
    input  logic [3:0]        in_reg,
    input  logic [11:0]       in_imm12,
    input  logic [23:0]       in_imm24,
    input  logic              start_load,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr
`ifdef ENC_FIELD_CHECK_EN
    ,
    output logic              err
`endif
);

    logic              stage_valid_q, stage_valid_d;
    logic [31:0]       stage_word_q, stage_word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       enc_word;
    logic [31:0]       fifo_head;
    logic              fifo_full, fifo_empty;
    logic              push, pop, in_fire, load, bad;

    assign enc_word = encode_word(in_cond, op_e'(in_op), in_imm_sel, in_bits,
                                  in_set_flags, in_link, in_base, in_reg,
                                  in_imm12, in_imm24);

`ifdef ENC_FIELD_CHECK_EN
    logic err_q, err_d;
    assign bad   = is_illegal(op_e'(in_op), in_imm_sel);
    assign err_d = in_fire && bad;
    assign err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`else
    assign bad = 1'b0;
`endif

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // The stage drains whenever the FIFO has room, including the full+pop case.
    assign push      = stage_valid_q && (!fifo_full || pop);
    assign in_ready  = !rst && (!stage_valid_q || push);
    assign in_fire   = in_valid && in_ready;
    assign load      = in_fire && !bad;

    assign out_word  = out_valid ? fifo_head : '0;
    assign out_addr  = addr_q;

    always_comb begin
        stage_valid_d = stage_valid_q;
        stage_word_d  = stage_word_q;
        if (push) stage_valid_d = 1'b0;
        if (load) begin
            stage_valid_d = 1'b1;
            stage_word_d  = enc_word;
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (start_load) addr_d = start_addr;
        else if (pop)   addr_d = addr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_word_q  <= '0;
            addr_q        <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            stage_word_q  <= stage_word_d;
            addr_q        <= addr_d;
        end
    end

    enc_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (stage_word_q),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic [1:0]  in_op;
    logic        in_imm_sel;
    logic [3:0]  in_bits;
    logic        in_set_flags;
    logic        in_link;
    logic [3:0]  in_base;
    logic [3:0]  in_reg;
    logic [11:0] in_imm12;
    logic [23:0] in_imm24;
    logic        start_load;
    logic [7:0]  start_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [7:0]  out_addr;
`ifdef ENC_FIELD_CHECK_EN
    logic        err;
`endif

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cond      (in_cond),
        .in_op        (in_op),
        .in_imm_sel   (in_imm_sel),
        .in_bits      (in_bits),
        .in_set_flags (in_set_flags),
        .in_link      (in_link),
        .in_base      (in_base),
        .in_reg       (in_reg),
        .in_imm12     (in_imm12),
        .in_imm24     (in_imm24),
        .start_load   (start_load),
        .start_addr   (start_addr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_addr     (out_addr)
`ifdef ENC_FIELD_CHECK_EN
        ,
        .err          (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic        imm_sel;
        logic [3:0]  bits;
        logic        s;
        logic        link;
        logic [3:0]  base;
        logic [3:0]  rg;
        logic [11:0] imm12;
        logic [23:0] imm24;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] cond, input logic [1:0] op,
                                input logic imm_sel, input logic [3:0] bits,
                                input logic s, input logic link,
                                input logic [3:0] base, input logic [3:0] rg,
                                input logic [11:0] imm12, input logic [23:0] imm24,
                                input logic [31:0] exp);
        vec_t v;
        v.cond = cond; v.op = op; v.imm_sel = imm_sel; v.bits = bits;
        v.s = s; v.link = link; v.base = base; v.rg = rg;
        v.imm12 = imm12; v.imm24 = imm24; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t bp_vec(input int k);
        return mk(4'h3, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0,
                  12'(k + 1), 24'h0, 32'h3000_0000 | 32'(k + 1));
    endfunction

    task automatic drive_vec(input vec_t v);
        in_cond = v.cond; in_op = v.op; in_imm_sel = v.imm_sel; in_bits = v.bits;
        in_set_flags = v.s; in_link = v.link; in_base = v.base; in_reg = v.rg;
        in_imm12 = v.imm12; in_imm24 = v.imm24;
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        drive_vec(v);
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [31:0] w);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_word"}, out_word, w);
        chk({name, "_addr"}, 32'(out_addr), 32'(exp_addr));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_addr = exp_addr + 8'd1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(4'hE, 2'b00, 1'b1, 4'h4, 1'b1, 1'b0, 4'h1, 4'h2, 12'h0FF, 24'hABCDEF, 32'hE291_20FF);
        vecs[1] = mk(4'hE, 2'b10, 1'b0, 4'hF, 1'b1, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'h000010, 32'hE900_0010);
        vecs[2] = mk(4'hE, 2'b01, 1'b0, 4'hF, 1'b1, 1'b1, 4'h3, 4'h4, 12'h008, 24'hFFFFFF, 32'hE503_4008);
        vecs[3] = mk(4'h0, 2'b00, 1'b0, 4'hD, 1'b0, 1'b0, 4'hA, 4'h5, 12'hABC, 24'h0,      32'h01AA_5ABC);
        vecs[4] = mk(4'h1, 2'b01, 1'b1, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 12'hFFF, 24'h0,      32'h160F_0FFF);
        vecs[5] = mk(4'h0, 2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h0,   24'hFFFFFF, 32'h08FF_FFFF);

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; start_load = 1'b0; start_addr = '0;
        drive_vec(vecs[0]);
        exp_addr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
`ifdef ENC_FIELD_CHECK_EN
        chk("rst_err", 32'(err), 32'd0);
`endif
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // table: each word goes through an empty FIFO, latency checked
        for (int i = 0; i < 6; i++) begin
            send(vecs[i]);
            chk($sformatf("v%0d_lat_stage", i), 32'(out_valid), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_lat_fifo", i), 32'(out_valid), 32'd1);
            expect_word($sformatf("v%0d", i), vecs[i].exp);
        end

        // reserved op and branch with imm_sel=1
`ifdef ENC_FIELD_CHECK_EN
        send(mk(4'h7, 2'b11, 1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFF, 32'h0));
        chk("rsvd_err_pulse", 32'(err), 32'd1);
        @(posedge clk); #1;
        chk("rsvd_err_clear", 32'(err), 32'd0);
        send(mk(4'h2, 2'b10, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 12'h0, 24'h123456, 32'h0));
        chk("brimm_err_pulse", 32'(err), 32'd1);
        @(posedge clk); #1;
        chk("brimm_err_clear", 32'(err), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("illegal_no_output", 32'(out_valid), 32'd0);
`else
        send(mk(4'h7, 2'b11, 1'b1, 4'hF, 1'b1, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFF, 32'h0));
        expect_word("rsvd", 32'h7C00_0000);
        send(mk(4'h2, 2'b10, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 12'h0, 24'h123456, 32'h0));
        expect_word("brimm", 32'h2912_3456);
`endif

        // back-pressure: 6 offered, 5 accepted
        begin
            int   acc;
            logic rdy;
            acc = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 15; c++) begin
                drive_vec(bp_vec(acc));
                in_valid = (acc < 6);
                rdy = in_ready;
                @(posedge clk); #1;
                if (rdy && in_valid) acc++;
            end
            in_valid = 1'b0;
            chk("bp_accepted", 32'(acc), 32'd5);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            for (int k = 0; k < 5; k++) expect_word($sformatf("bp%0d", k), bp_vec(k).exp);
            repeat (3) @(posedge clk);
            #1;
            chk("bp_drained", 32'(out_valid), 32'd0);
        end

        // start_load and address wrap
        start_addr = 8'hFF; start_load = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0;
        exp_addr = 8'hFF;
        chk("sl_addr", 32'(out_addr), 32'h0FF);
        send(vecs[0]);
        expect_word("wrap0", vecs[0].exp);
        send(vecs[3]);
        expect_word("wrap1", vecs[3].exp);
        chk("wrap_model", 32'(exp_addr), 32'h001);

        // start_load beats the increment on a transfer cycle; FIFO kept
        send(vecs[4]);
        send(vecs[5]);
        repeat (2) @(posedge clk);
        #1;
        chk("prio_head", out_word, vecs[4].exp);
        out_ready = 1'b1; start_load = 1'b1; start_addr = 8'h40;
        @(posedge clk); #1;
        out_ready = 1'b0; start_load = 1'b0;
        exp_addr = 8'h40;
        expect_word("prio_next", vecs[5].exp);

        // reset with 3 words buffered
        send(bp_vec(0));
        send(bp_vec(1));
        send(bp_vec(2));
        repeat (2) @(posedge clk);
        #1;
        chk("mid_valid_before", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", 32'(out_addr), 32'd0);
        chk("mid_rst_word", out_word, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr = 8'h00;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        chk("mid_addr_held", 32'(out_addr), 32'd0);
        send(vecs[2]);
        expect_word("after_rst", vecs[2].exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
